// File: rtl/serial_adder_pkg.sv
// Shared types for the byte-serial adder/accumulator core: operation codes,
// FSM states and flag bit positions.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ACC = 2'b10,
        CLR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD_A = 2'b01,
        LOAD_B = 2'b10,
        OUT    = 2'b11
    } state_e;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;

endpackage

// File: rtl/byte_add_slice.sv
// 8-bit adder slice with carry-in and optional B inversion; also exposes the
// carry into bit 7 so the caller can derive signed overflow.
module byte_add_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       inv,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       msb_cin
);
    logic [7:0] b_eff;
    logic [6:0] low7;
    logic [1:0] top;

    assign b_eff = inv ? ~b : b;
    assign {msb_cin, low7} = {1'b0, a[6:0]} + {1'b0, b_eff[6:0]} + {7'b0, cin};
    assign top = {1'b0, a[7]} + {1'b0, b_eff[7]} + {1'b0, msb_cin};
    assign sum  = {top[0], low7};
    assign cout = top[1];

endmodule

// File: rtl/serial_adder_core.sv
// Byte-serial add/sub/accumulate core with valid/ready byte streams in and out.
// Define SERIAL_ADDER_SAT_EN to clamp results to the signed extreme on overflow.
module serial_adder_core
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [1:0] op,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [2:0] flags
);
    localparam int NB = WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NB - 1);

    state_e              state_q, state_nxt;
    op_e                 op_q, op_nxt, op_cur;
    logic [IW-1:0]       idx_q, idx_nxt;
    logic                c_q, c_nxt;
    logic [NB-1:0][7:0]  a_q, a_nxt;
    logic [NB-1:0][7:0]  res_q, res_nxt, res_fin;
    logic [NB-1:0][7:0]  acc_q, acc_nxt;
    logic [2:0]          flags_q, flags_nxt;

    logic [7:0] s_a, s_sum;
    logic       s_inv, s_cin, s_cout, s_msb, ovf;
    logic       accept, last_beat;

    // The op input only matters on the opening byte; afterwards the latched copy rules.
    assign op_cur = (state_q == IDLE) ? op_e'(op) : op_q;
    assign s_a    = (op_cur == ACC) ? acc_q[idx_q] : a_q[idx_q];
    assign s_inv  = (op_cur == SUB);
    assign s_cin  = (idx_q == '0) ? (op_cur == SUB) : c_q;
    assign ovf    = s_cout ^ s_msb;

    byte_add_slice u_slice (
        .a       (s_a),
        .b       (in_data),
        .inv     (s_inv),
        .cin     (s_cin),
        .sum     (s_sum),
        .cout    (s_cout),
        .msb_cin (s_msb)
    );

    assign in_ready  = ena && (state_q != OUT);
    assign out_valid = ena && (state_q == OUT);
    assign accept    = in_valid && in_ready;
    assign out_data  = res_q[idx_q];
    assign out_last  = (state_q == OUT) && (idx_q == LAST);
    assign flags     = flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        op_nxt    = op_q;
        idx_nxt   = idx_q;
        c_nxt     = c_q;
        a_nxt     = a_q;
        res_nxt   = res_q;
        acc_nxt   = acc_q;
        flags_nxt = flags_q;
        res_fin   = '0;
        last_beat = 1'b0;

        case (state_q)
            IDLE, LOAD_A: begin
                if (accept) begin
                    op_nxt = op_cur;
                    if (op_cur == CLR) begin
                        acc_nxt = '0;
                    end else begin
                        a_nxt[idx_q] = in_data;
                        // ACC folds each A byte into acc as it arrives
                        if (op_cur == ACC) begin
                            res_nxt[idx_q] = s_sum;
                            c_nxt          = s_cout;
                        end
                        if (idx_q == LAST) begin
                            if (op_cur == ACC) begin
                                last_beat = 1'b1;
                            end else begin
                                state_nxt = LOAD_B;
                                idx_nxt   = '0;
                            end
                        end else begin
                            state_nxt = LOAD_A;
                            idx_nxt   = idx_q + 1'b1;
                        end
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    res_nxt[idx_q] = s_sum;
                    c_nxt          = s_cout;
                    if (idx_q == LAST) begin
                        last_beat = 1'b1;
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (last_beat) begin
            res_fin = res_nxt;
`ifdef SERIAL_ADDER_SAT_EN
            // On overflow both operands share a sign, so the A-side MSB picks the rail.
            if (ovf) begin
                res_fin = s_a[7] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
            res_nxt               = res_fin;
            flags_nxt[FLAG_ZERO]  = (res_fin == '0);
            flags_nxt[FLAG_OVF]   = ovf;
            flags_nxt[FLAG_CARRY] = s_cout;
            if (op_cur == ACC) begin
                acc_nxt = res_fin;
            end
            state_nxt = OUT;
            idx_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= ADD;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            flags_q <= '0;
        end else if (ena) begin
            op_q    <= op_nxt;
            idx_q   <= idx_nxt;
            c_q     <= c_nxt;
            a_q     <= a_nxt;
            res_q   <= res_nxt;
            acc_q   <= acc_nxt;
            flags_q <= flags_nxt;
        end
    end

endmodule

// File: doc/serial_adder_core.md
# serial_adder_core

Parametrised byte-serial adder/accumulator core: the multi-byte successor to the single-byte adder project. Operands wider than the 8-bit pad bus stream in LSB-first over a valid/ready byte interface. The core adds, subtracts or accumulates one byte per accepted beat with a registered carry, then streams the result back out byte-serially with flags. It sits directly behind the top-level pin wrapper: `ui_in` feeds the data path, `uo_out` carries results, and `uio` carries handshake and flags.

## Interface
- `WIDTH`, default 32: operand/result width in bits. Must be a multiple of 8, range 8..64.
- `NB`, derived as WIDTH/8: bytes per operand. Not user-overridable.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high. Clears all state.
- `ena` input 1: design enable. When low, the core freezes all state, and `in_ready` and `out_valid` are forced to 0.
- `op` input 2: operation code, sampled with the first byte of each transaction. 00 ADD, 01 SUB (A−B), 10 ACC (acc += A), 11 CLR (acc := 0).
- `in_valid` input 1: `in_data` carries a valid byte.
- `in_ready` output 1: core accepts a byte this cycle. A transfer occurs when `in_valid` and `in_ready` are both high.
- `in_data` input 8: operand byte, LSB-first.
- `out_valid` output 1: `out_data` carries a valid result byte.
- `out_ready` input 1: sink accepts a result byte.
- `out_data` output 8: result byte, LSB-first.
- `out_last` output 1: marks the final result byte.
- `flags` output 3: {zero, overflow, carry}. Valid whenever `out_valid` is high; constant across one result.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, OUT.
- IDLE: `in_ready`=1.
  - The first accepted byte latches `op` and is handled as A byte 0.
  - For CLR, that byte is consumed and discarded, acc is cleared, and the FSM stays in IDLE.
  - For other ops, the FSM moves to LOAD_A (or directly to OUT or LOAD_B when NB=1, per the rules below).
- LOAD_A: accepts A bytes 1..NB−1 into the A register.
  - After the last A byte, ADD and SUB go to LOAD_B.
  - ACC goes to OUT, with result = acc + A computed byte-serially as the A bytes arrive; acc is updated to the result.
- LOAD_B: each accepted B byte k computes res[k] = A[k] + (SUB ? ~B[k] : B[k]) + c, and writes c ← carry-out.
  - Initial c is 0 for ADD/ACC and 1 for SUB.
  - After byte NB−1 the FSM goes to OUT.
- OUT: presents res bytes 0..NB−1 with `out_valid`=1 and `in_ready`=0.
  - The byte index advances on each `out_valid`&`out_ready` transfer.
  - `out_last`=1 on byte NB−1; its transfer returns the FSM to IDLE.
- Flags:
  - carry = final carry-out. For SUB this means "no borrow".
  - overflow = signed overflow, taken from the carry into and out of the MSB.
  - zero = res == 0. Under saturation, zero is computed on the post-clamp value.
- Arithmetic is modulo 2^WIDTH, except as modified under Configuration.
- Reset values:
  - FSM = IDLE; A, res, acc, byte index, carry and flags = 0.
  - `in_ready`=1 (when `ena`=1); `out_valid`=0, `out_last`=0, `out_data`=0.
- Reset asserted mid-transaction discards partial operands and clears acc. The next accepted byte starts a new transaction.
- `ena` low mid-transaction: all state is held. The transaction resumes when `ena` returns high.

## Timing
- One byte is accepted per cycle. There are no bubbles in a back-to-back input stream.
- Latency: `out_valid` rises in the cycle immediately after the edge that accepts the final operand byte.
- `out_data`, `out_last` and `flags` are registered or driven from registered state. They must be stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` and `out_valid` are never high in the same cycle. A new transaction cannot start until the last output byte is transferred.
- `in_ready` depends on state and `ena` only, never combinationally on `in_valid`.
- Throughput: 2·NB + NB cycles per ADD/SUB transaction and NB + NB per ACC, assuming `out_ready` held high.

## Configuration
- `SERIAL_ADDER_SAT_EN` defined: on signed overflow, the OUT-phase result is clamped to the signed extreme.
  - Positive overflow gives 0x7F..F; negative overflow gives 0x80..0.
  - For ACC, the clamped value is also written to acc.
  - The clamp is applied when entering OUT, using the sign of A and the overflow flag. This adds no latency.
  - The overflow flag still reports that overflow occurred.
- Not defined: results wrap modulo 2^WIDTH and no clamp logic is synthesised.

## Structure
- Package `serial_adder_pkg` holds:
  - the `op_e` enum (ADD, SUB, ACC, CLR);
  - the `state_e` enum (IDLE, LOAD_A, LOAD_B, OUT);
  - flag bit-position constants.
- One sub-module, `byte_add_slice`: 8-bit add with carry-in and optional B inversion, outputs sum, carry-out and MSB carry-in (for overflow). It is combinational, instantiated once and reused every beat.

## Test plan
- WIDTH=16, ADD A=0x1234, B=0x0FCD → bytes 0x01, 0x22; flags carry=0, ovf=0, zero=0; `out_valid` rises 1 cycle after the 4th input byte.
- WIDTH=16, SUB A=0x0000, B=0x0001 → 0xFFFF, carry=0 (borrow); SUB A=0x8000, B=0x0001 → 0x7FFF with ovf=1 without SAT_EN, 0x8000 with ovf=1 with SAT_EN.
- WIDTH=32, ACC three times with 0xFFFFFFFF after CLR → outputs 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD; carry=1 on the 2nd and 3rd.
- Back-pressure: hold `out_ready`=0 for 5 cycles mid-output → `out_data`/`out_last`/`flags` stable and `in_ready`=0; then full result delivered in order.
- Assert `rst` after 3 bytes of a WIDTH=32 ADD, then run ADD 1+1 → result 0x00000002, acc=0, no stale bytes.
- Toggle `ena` low for 4 cycles during LOAD_B with `in_valid`=1 → no bytes accepted; final result identical to the uninterrupted run.
